// File: rtl/smg_share_ctrl.sv
// smg_share_ctrl: shares one 4-digit multiplexed seven-segment display
// between up to four requesters. Round-robin arbitration, a minimum hold
// time per winner, sequential binary-to-BCD conversion (shift-add-3) and a
// free-running digit scan.
// Optional feature: define SMG_LZB_EN to enable leading-zero blanking.
//
// Request/grant handshake: REQ[i] is a level. When the arbiter picks i, it
// captures DATA_BUS slice i on that edge and pulses GNT[i] high for exactly
// the following cycle. No grant is ever issued to a requester whose REQ was
// low in the arbitration cycle. REQ may be dropped at any time; a dropped
// request is simply not served.
module smg_share_ctrl #(
    parameter int N_REQ    = 4,
    parameter int SCAN_DIV = 50000,
    parameter int HOLD_CYC = 50000000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_REQ-1:0]      REQ,
    input  logic [16*N_REQ-1:0]   DATA_BUS,
    output logic [N_REQ-1:0]      GNT,
    output logic [1:0]            OWNER,
    output logic                  BUSY,
    output logic [2:0]            SEL,
    output logic [7:0]            DUAN
);

    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int PW = $clog2(SCAN_DIV);

    // Digit register codes: 0..9 are decimal digits, ERR shows the
    // overflow pattern, BLANK shows nothing.
    localparam logic [3:0] CODE_ERR   = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {IDLE, ARB, CONV, SHOW} state_t;

    // state is the observable FSM state (probe hierarchically for debug).
    state_t            state, state_nxt;
    logic [1:0]        ptr;
    logic [2:0]        cand;
    logic [7:0]        req_pad;
    logic [1:0]        win;
    logic              win_ok;
    logic [15:0]       data_sel;
    logic [15:0]       bin;
    logic [19:0]       bcd;
    logic [19:0]       bcd_adj;
    logic [19:0]       bcd_nxt;
    logic [3:0]        bit_cnt;
    logic [3:0]        dig [4];
    logic              shown;
    logic [HW-1:0]     hold;
    logic [PW-1:0]     presc;
    logic [2:0]        sel_nxt;
    logic [7:0]        pat;

    function automatic logic [7:0] seg7(input logic [3:0] c);
        case (c)
            4'd0:    seg7 = 8'h3F;
            4'd1:    seg7 = 8'h06;
            4'd2:    seg7 = 8'h5B;
            4'd3:    seg7 = 8'h4F;
            4'd4:    seg7 = 8'h66;
            4'd5:    seg7 = 8'h6D;
            4'd6:    seg7 = 8'h7D;
            4'd7:    seg7 = 8'h07;
            4'd8:    seg7 = 8'h7F;
            4'd9:    seg7 = 8'h6F;
            4'hE:    seg7 = 8'hF9;
            default: seg7 = 8'h00;
        endcase
    endfunction

    assign req_pad = 8'(REQ);

    // Round-robin winner: scan from farthest to nearest after ptr so the
    // nearest requesting index is the one left standing.
    always_comb begin
        win    = ptr;
        win_ok = 1'b0;
        cand   = 3'd0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = 3'(ptr) + 3'(k);
            if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
            if (req_pad[cand]) begin
                win    = cand[1:0];
                win_ok = 1'b1;
            end
        end
    end

    // Select the winner's data slice with a constant-index mux.
    always_comb begin
        data_sel = DATA_BUS[15:0];
        for (int i = 0; i < N_REQ; i++) begin
            if (win == 2'(i)) data_sel = DATA_BUS[16*i +: 16];
        end
    end

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift.
    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < 5; n++) begin
            if (bcd[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
        end
        bcd_nxt = {bcd_adj[18:0], bin[15]};
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (|REQ) state_nxt = ARB;
            ARB: begin
                if (win_ok)     state_nxt = CONV;
                else if (shown) state_nxt = SHOW;
                else            state_nxt = IDLE;
            end
            CONV: if (bit_cnt == 4'd15) state_nxt = SHOW;
            SHOW: if (hold == HW'(HOLD_CYC) && |REQ) state_nxt = ARB;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        BUSY = (state == ARB) || (state == CONV);
    end

    // Arbitration capture, conversion datapath, digit registers and hold timer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            GNT     <= '0;
            OWNER   <= 2'd0;
            ptr     <= 2'(N_REQ - 1);
            bin     <= 16'd0;
            bcd     <= 20'd0;
            bit_cnt <= 4'd0;
            shown   <= 1'b0;
            hold    <= '0;
            for (int i = 0; i < 4; i++) dig[i] <= CODE_BLANK;
        end else begin
            GNT <= '0;
            case (state)
                ARB: begin
                    if (win_ok) begin
                        GNT     <= N_REQ'(1) << win;
                        OWNER   <= win;
                        ptr     <= win;
                        bin     <= data_sel;
                        bcd     <= 20'd0;
                        bit_cnt <= 4'd0;
                    end
                end
                CONV: begin
                    bin     <= {bin[14:0], 1'b0};
                    bcd     <= bcd_nxt;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        // All four digits change on the same edge.
                        for (int i = 0; i < 4; i++) begin
                            if (bcd_nxt[19:16] != 4'd0) dig[i] <= CODE_ERR;
                            else                        dig[i] <= bcd_nxt[4*(3-i) +: 4];
                        end
                        shown <= 1'b1;
                        hold  <= '0;
                    end
                end
                SHOW: if (hold != HW'(HOLD_CYC)) hold <= hold + HW'(1);
                default: ;
            endcase
        end
    end

    // Digit select advance and segment pattern for the upcoming slot.
    always_comb begin
        if (presc == PW'(SCAN_DIV - 1)) sel_nxt = (SEL == 3'd3) ? 3'd0 : SEL + 3'd1;
        else                            sel_nxt = SEL;
        pat = seg7(dig[sel_nxt[1:0]]);
`ifdef SMG_LZB_EN
        // Blank zeros left of the first non-zero digit; units always shown.
        if (sel_nxt[1:0] != 2'd3) begin
            if (dig[0] == 4'd0 &&
                (sel_nxt[1:0] == 2'd0 || dig[1] == 4'd0) &&
                (sel_nxt[1:0] != 2'd2 || dig[2] == 4'd0))
                pat = 8'h00;
        end
`endif
    end

    // Free-running scan prescaler, SEL and registered DUAN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
            SEL   <= 3'd0;
            DUAN  <= 8'h00;
        end else begin
            if (presc == PW'(SCAN_DIV - 1)) presc <= '0;
            else                            presc <= presc + PW'(1);
            SEL  <= sel_nxt;
            DUAN <= pat;
        end
    end

endmodule

// File: tb/tb_smg_share_ctrl.sv
// tb_smg_share_ctrl: self-checking bench for smg_share_ctrl with a
// transaction-level reference model (round-robin pick, decimal digits by
// arithmetic, scan position from elapsed cycles).
module tb_smg_share_ctrl;
    localparam int N_REQ    = 4;
    localparam int SCAN_DIV = 4;
    localparam int HOLD_CYC = 64;
    localparam int LAT      = 17;                     // GNT rise -> new DUAN
    localparam int MIN_GAP  = 16 + HOLD_CYC + 2;      // edges between grants

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [N_REQ-1:0]      REQ;
    logic [16*N_REQ-1:0]   DATA_BUS;
    logic [N_REQ-1:0]      GNT;
    logic [1:0]            OWNER;
    logic                  BUSY;
    logic [2:0]            SEL;
    logic [7:0]            DUAN;

    smg_share_ctrl #(.N_REQ(N_REQ), .SCAN_DIV(SCAN_DIV), .HOLD_CYC(HOLD_CYC)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .DATA_BUS(DATA_BUS),
        .GNT(GNT), .OWNER(OWNER), .BUSY(BUSY), .SEL(SEL), .DUAN(DUAN)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0]          exp_q[$];          // expected grant order (round-robin phase)
    logic [N_REQ-1:0]    req_s;
    logic [16*N_REQ-1:0] data_s;
    int  k = 0, rr_ptr = N_REQ - 1, own = 0, gcount = 0;
    int  vis_val = 0, pend_val = 0, age = 0, last_g = -1, rr_cnt = 0;
    int  busy_run = 0;
    bit  vis_valid = 0, pending = 0, busy_gnt = 0, rr_exact = 0;

    function automatic logic [7:0] seg(input int d);
        case (d)
            0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
            4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
            8: return 8'h7F; default: return 8'h6F;
        endcase
    endfunction

    function automatic logic [7:0] exp_duan(input bit valid, input int val, input int s);
        int p;
        if (!valid) return 8'h00;
        if (val > 9999) return 8'hF9;
        p = (s == 0) ? 1000 : (s == 1) ? 100 : (s == 2) ? 10 : 1;
`ifdef SMG_LZB_EN
        if (s < 3 && val < p) return 8'h00;
`endif
        return seg((val / p) % 10);
    endfunction

    function automatic int rr_pick(input int p, input logic [N_REQ-1:0] r);
        for (int j = 1; j <= N_REQ; j++) begin
            if (r[(p + j) % N_REQ]) return (p + j) % N_REQ;
        end
        return -1;
    endfunction

    // Inputs as seen by the DUT on each active edge.
    always @(posedge CLK) begin
        req_s  = REQ;
        data_s = DATA_BUS;
    end

    // Scoreboard: compare every output each cycle away from the active edge.
    always @(negedge CLK) begin
        int w;
        if (RST) begin
            k = 0; rr_ptr = N_REQ - 1; own = 0; vis_valid = 0; pending = 0;
            last_g = -1; busy_run = 0; busy_gnt = 0; rr_cnt = 0;
            check("rst_gnt", 32'(GNT), 0);
            check("rst_owner", 32'(OWNER), 0);
            check("rst_busy", 32'(BUSY), 0);
            check("rst_sel", 32'(SEL), 0);
            check("rst_duan", 32'(DUAN), 0);
        end else begin
            k++;
            if (pending) begin
                age++;
                if (age == LAT) begin
                    vis_val = pend_val; vis_valid = 1; pending = 0;
                end
            end
            if (GNT != '0) begin
                w = rr_pick(rr_ptr, req_s);
                check("gnt_onehot", 32'(GNT), (w < 0) ? 0 : (1 << w));
                if (w >= 0) begin
                    rr_ptr = w; own = w; gcount++;
                    pend_val = int'(data_s[16*w +: 16]); pending = 1; age = 0;
                    if (last_g >= 0) check("gap_min", 32'(k - last_g >= MIN_GAP), 1);
                    if (rr_exact) begin
                        if (rr_cnt > 0) check("gap_exact", 32'(k - last_g), MIN_GAP);
                        rr_cnt++;
                    end else rr_cnt = 0;
                    if (exp_q.size() > 0) check("rr_order", 32'(w), 32'(exp_q.pop_front()));
                    last_g = k;
                end
                busy_gnt = 1;
            end
            check("owner", 32'(OWNER), own);
            check("sel", 32'(SEL), (k / SCAN_DIV) % 4);
            check("duan", 32'(DUAN), 32'(exp_duan(vis_valid, vis_val, (k / SCAN_DIV) % 4)));
            if (BUSY) busy_run++;
            else if (busy_run > 0) begin
                check("busy_len", busy_run, busy_gnt ? 17 : 1);
                busy_run = 0; busy_gnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic rst_pulse(input int n);
        RST = 1'b1;
        tick(n);
        RST = 1'b0;
    endtask

    task automatic set_data(input int i, input int v);
        DATA_BUS[16*i +: 16] = 16'(v);
    endtask

    task automatic wait_grant(input int budget);
        int start = gcount;
        int t = 0;
        while (gcount == start && t < budget) begin
            @(negedge CLK); #1;
            t++;
        end
        if (gcount == start) check("grant_timeout", 0, 1);
    endtask

    task automatic serve(input int i, input int v);
        set_data(i, v);
        REQ = N_REQ'(1) << i;
        wait_grant(200);
        REQ = '0;
        tick(100);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g0;
        RST = 1'b1; REQ = '0; DATA_BUS = '0;
        tick(3);
        RST = 1'b0;
        tick(20);                   // no request: display stays blank
        tick(6);
        rst_pulse(2);               // reset mid-scan
        tick(10);

        serve(2, 1234);             // single request
        serve(0, 10000);            // overflow cases
        serve(1, 65535);
        serve(3, 9999);

        // Request dropped while holding: no grant, nothing changes.
        set_data(3, 1111);
        REQ = '0; g0 = gcount;
        set_data(1, 4321);
        serve(2, 500);
        tick(0);
        g0 = gcount;
        tick(10);
        REQ = 4'b0010;
        tick(1);
        REQ = '0;
        tick(120);
        check("drop_no_grant", 32'(gcount), 32'(g0));

        // Round-robin with requester 2 idle; pointer currently at 2.
        set_data(0, 10); set_data(1, 20); set_data(2, 30); set_data(3, 40);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        rr_exact = 1;
        REQ = 4'b1011;
        repeat (5) wait_grant(300);
        REQ = '0;
        rr_exact = 0;
        tick(100);

        // Reset in the middle of a conversion, then a fresh request.
        set_data(2, 7777);
        REQ = 4'b0100;
        wait_grant(200);
        REQ = '0;
        tick(7);
        rst_pulse(2);
        tick(20);
        serve(0, 42);

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N_REQ; i++) begin
                case ($urandom_range(0, 3))
                    0:       set_data(i, $urandom_range(0, 9));
                    1:       set_data(i, $urandom_range(0, 9999));
                    2:       set_data(i, $urandom_range(9990, 10010));
                    default: set_data(i, $urandom_range(0, 65535));
                endcase
            end
            REQ = N_REQ'($urandom_range(0, 15));
            tick($urandom_range(1, 150));
        end
        REQ = '0;
        tick(120);

        check("rr_queue_empty", 32'(exp_q.size()), 0);
        check("grants_seen_min", 32'(gcount >= 12), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
